mem_io_responder: RTL and testbench

Bus-side responder for the CPU memory port: owns the 128 KB byte RAM, the 0x30000/0x30004 I/O registers and the free-running cycle counter. It answers the CPU's byte-wide address/data/write bus with a registered one-cycle read latency. It also buffers the byte streams to and from the UART-facing logic in two FIFOs, and throttles the CPU through `cpu_rdy` when output buffering is exhausted or the program has halted.

---
 rtl/mem_io_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_io_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// CPU memory-port responder: byte RAM, UART in/out byte FIFOs, cycle counter with snapshot,
// and a sticky halt register. Read data is registered with one cycle of latency.
module mem_io_responder #(
    parameter int unsigned RAM_AW  = 17,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halt
);

    localparam int unsigned Depth   = 1 << FIFO_AW;
    localparam int unsigned RamSize = 1 << RAM_AW;

    localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

    localparam logic [2:0] IoData = 3'd0;
    localparam logic [2:0] IoCnt0 = 3'd4;
    localparam logic [2:0] IoCnt1 = 3'd5;
    localparam logic [2:0] IoCnt2 = 3'd6;
    localparam logic [2:0] IoCnt3 = 3'd7;

    // Bus decode
    logic              sel_ram;
    logic              sel_io;
    logic [2:0]        io_reg;
    logic              acc_rd;
    logic              acc_wr;
    logic [RAM_AW-1:0] ram_addr;
    logic              unused_a;

    // Storage
    logic [7:0] ram     [RamSize];
    logic [7:0] in_mem  [Depth];
    logic [7:0] out_mem [Depth];
    logic [7:0] ram_rd_q;

    // FIFO pointers and control
    logic [FIFO_AW:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [FIFO_AW:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic             in_full, in_empty, in_push, in_pop;
    logic             out_full, out_empty, out_push, out_pop;
    logic [7:0]       out_push_data;

    // Read path, counter, halt
    logic        rd_src_ram_q, rd_src_ram_d;
    logic [7:0]  io_rdata_q, io_rdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        halt_q, halt_d;

    assign unused_a = ^cpu_a[31:18];
    assign ram_addr = cpu_a[RAM_AW-1:0];

    always_comb begin
        sel_ram = ~cpu_a[17];
        sel_io  = cpu_a[17] & cpu_a[16];
        io_reg  = cpu_a[2:0];
        acc_rd  = cpu_rdy & ~cpu_wr;
        acc_wr  = cpu_rdy & cpu_wr;
    end

    // Full/empty from registered pointers only, so a pop frees space for the next cycle.
    always_comb begin
        in_empty  = (in_wptr_q == in_rptr_q);
        in_full   = (in_wptr_q[FIFO_AW] != in_rptr_q[FIFO_AW]) &&
                    (in_wptr_q[FIFO_AW-1:0] == in_rptr_q[FIFO_AW-1:0]);
        out_empty = (out_wptr_q == out_rptr_q);
        out_full  = (out_wptr_q[FIFO_AW] != out_rptr_q[FIFO_AW]) &&
                    (out_wptr_q[FIFO_AW-1:0] == out_rptr_q[FIFO_AW-1:0]);
    end

    always_comb begin
        in_push       = in_valid & ~in_full;
        in_pop        = acc_rd & sel_io & (io_reg == IoData) & ~in_empty;
        out_push      = acc_wr & sel_io &
                        (((io_reg == IoData) & (cpu_wdata != 8'h00)) | (io_reg == IoCnt0));
        out_push_data = (io_reg == IoCnt0) ? 8'h00 : cpu_wdata;
        out_pop       = ~out_empty & out_ready;

        in_wptr_d  = in_push  ? in_wptr_q  + PtrOne : in_wptr_q;
        in_rptr_d  = in_pop   ? in_rptr_q  + PtrOne : in_rptr_q;
        out_wptr_d = out_push ? out_wptr_q + PtrOne : out_wptr_q;
        out_rptr_d = out_pop  ? out_rptr_q + PtrOne : out_rptr_q;
    end

    // RAM and FIFO storage carry no reset; only the pointers define their contents.
    always_ff @(posedge clk_in) begin
        if (acc_wr && sel_ram) begin
            ram[ram_addr] <= cpu_wdata;
        end
        if (acc_rd && sel_ram) begin
            ram_rd_q <= ram[ram_addr];
        end
        if (in_push) begin
            in_mem[in_wptr_q[FIFO_AW-1:0]] <= in_data;
        end
        if (out_push) begin
            out_mem[out_wptr_q[FIFO_AW-1:0]] <= out_push_data;
        end
    end

    // Non-RAM read data is built here; the RAM byte comes straight from ram_rd_q.
    always_comb begin
        rd_src_ram_d = rd_src_ram_q;
        io_rdata_d   = io_rdata_q;
        snap_d       = snap_q;
        if (acc_rd) begin
            rd_src_ram_d = sel_ram;
            io_rdata_d   = 8'h00;
            if (sel_io) begin
                case (io_reg)
                    IoData: io_rdata_d = in_empty ? 8'h00 : in_mem[in_rptr_q[FIFO_AW-1:0]];
                    IoCnt0: begin
                        io_rdata_d = cnt_q[7:0];
                        snap_d     = cnt_q;
                    end
                    IoCnt1:  io_rdata_d = snap_q[15:8];
                    IoCnt2:  io_rdata_d = snap_q[23:16];
                    IoCnt3:  io_rdata_d = snap_q[31:24];
                    default: io_rdata_d = 8'h00;
                endcase
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q + 32'd1;
        halt_d = halt_q | (acc_wr & sel_io & (io_reg == IoCnt0));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            in_wptr_q    <= '0;
            in_rptr_q    <= '0;
            out_wptr_q   <= '0;
            out_rptr_q   <= '0;
            rd_src_ram_q <= 1'b0;
            io_rdata_q   <= 8'h00;
            cnt_q        <= 32'd0;
            snap_q       <= 32'd0;
            halt_q       <= 1'b0;
        end else begin
            in_wptr_q    <= in_wptr_d;
            in_rptr_q    <= in_rptr_d;
            out_wptr_q   <= out_wptr_d;
            out_rptr_q   <= out_rptr_d;
            rd_src_ram_q <= rd_src_ram_d;
            io_rdata_q   <= io_rdata_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            halt_q       <= halt_d;
        end
    end

    always_comb begin
        cpu_rdy   = ~rst_in & ~halt_q & ~out_full;
        cpu_rdata = rd_src_ram_q ? ram_rd_q : io_rdata_q;
        in_ready  = ~in_full;
        out_valid = ~out_empty;
        out_data  = out_empty ? 8'h00 : out_mem[out_rptr_q[FIFO_AW-1:0]];
        halt      = halt_q;
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: queue/array reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        halt;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(
        .RAM_AW (17),
        .FIFO_AW(4)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .cpu_a    (cpu_a),
        .cpu_wdata(cpu_wdata),
        .cpu_wr   (cpu_wr),
        .cpu_rdata(cpu_rdata),
        .cpu_rdy  (cpu_rdy),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .halt     (halt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: RAM as a sparse map, FIFOs as queues, counter as a plain integer.
    logic [7:0]  m_ram [int];
    logic [7:0]  m_inq [$];
    logic [7:0]  m_outq[$];
    logic [31:0] m_cnt    = 32'd0;
    logic [31:0] m_snap   = 32'd0;
    bit          m_cnt_ok = 1'b1;
    bit          m_halt   = 1'b0;
    logic [7:0]  m_rdata  = 8'h00;
    bit          m_rd_ok  = 1'b1;

    task automatic model_reset();
        m_inq.delete();
        m_outq.delete();
        m_cnt    = 32'd0;
        m_snap   = 32'd0;
        m_cnt_ok = 1'b1;
        m_halt   = 1'b0;
        m_rdata  = 8'h00;
        m_rd_ok  = 1'b1;
    endtask

    task automatic model_step();
        bit         acc;
        bit         push_in;
        logic [7:0] byte_in;
        int         key;
        acc     = !m_halt && (m_outq.size() < 16);
        push_in = in_valid && (m_inq.size() < 16);
        byte_in = in_data;
        key     = int'(cpu_a[16:0]);
        if (m_outq.size() > 0 && out_ready) void'(m_outq.pop_front());
        if (acc && !cpu_wr) begin
            m_rd_ok = 1'b1;
            if (!cpu_a[17]) begin
                if (m_ram.exists(key)) m_rdata = m_ram[key];
                else m_rd_ok = 1'b0;
            end else if (!cpu_a[16]) begin
                m_rdata = 8'h00;
            end else begin
                case (cpu_a[2:0])
                    3'd0: m_rdata = (m_inq.size() > 0) ? m_inq.pop_front() : 8'h00;
                    3'd4: begin
                        m_rdata = m_cnt[7:0];
                        m_snap  = m_cnt;
                        m_rd_ok = m_cnt_ok;
                    end
                    3'd5: begin m_rdata = m_snap[15:8];  m_rd_ok = m_cnt_ok; end
                    3'd6: begin m_rdata = m_snap[23:16]; m_rd_ok = m_cnt_ok; end
                    3'd7: begin m_rdata = m_snap[31:24]; m_rd_ok = m_cnt_ok; end
                    default: m_rdata = 8'h00;
                endcase
            end
        end
        if (acc && cpu_wr) begin
            if (!cpu_a[17]) m_ram[key] = cpu_wdata;
            else if (cpu_a[16] && cpu_a[2:0] == 3'd0 && cpu_wdata != 8'h00)
                m_outq.push_back(cpu_wdata);
            else if (cpu_a[16] && cpu_a[2:0] == 3'd4) begin
                m_outq.push_back(8'h00);
                m_halt = 1'b1;
            end
        end
        if (push_in) m_inq.push_back(byte_in);
        m_cnt = m_cnt + 32'd1;
    endtask

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) model_reset();
        else model_step();
    end

    // Bytes actually consumed from the output FIFO.
    logic [7:0] popped[$];
    always @(posedge clk_in) begin
        if (!rst_in && out_valid && out_ready) popped.push_back(out_data);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (rst_in) begin
            chk("rst cpu_rdy", 32'(cpu_rdy), 32'd0);
            chk("rst cpu_rdata", 32'(cpu_rdata), 32'd0);
            chk("rst out_valid", 32'(out_valid), 32'd0);
            chk("rst out_data", 32'(out_data), 32'd0);
            chk("rst halt", 32'(halt), 32'd0);
        end else begin
            chk("cpu_rdy", 32'(cpu_rdy), 32'(!m_halt && m_outq.size() < 16));
            chk("in_ready", 32'(in_ready), 32'(m_inq.size() < 16));
            chk("out_valid", 32'(out_valid), 32'(m_outq.size() > 0));
            chk("out_data", 32'(out_data), 32'((m_outq.size() > 0) ? m_outq[0] : 8'h00));
            chk("halt", 32'(halt), 32'(m_halt));
            if (m_rd_ok) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // Bus parked on a write to the unmapped region: no side effects, read data held.
    task automatic idle();
        cpu_a     = 32'h0002_0000;
        cpu_wr    = 1'b1;
        cpu_wdata = 8'h00;
    endtask

    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        int waited;
        waited    = 0;
        cpu_a     = a;
        cpu_wr    = wr;
        cpu_wdata = d;
        while (!cpu_rdy && waited < 64) begin
            tick();
            waited++;
        end
        if (!cpu_rdy) chk("bus accept", 32'(cpu_rdy), 32'd1);
        else tick();
        idle();
    endtask

    logic [7:0] b0, b1, b2, b3;

    task automatic read_dword(output logic [31:0] v);
        cpu_wr = 1'b0;
        cpu_a  = 32'h0003_0004; tick(); b0 = cpu_rdata;
        cpu_a  = 32'h0003_0005; tick(); b1 = cpu_rdata;
        cpu_a  = 32'h0003_0006; tick(); b2 = cpu_rdata;
        cpu_a  = 32'h0003_0007; tick(); b3 = cpu_rdata;
        idle();
        v = {b3, b2, b1, b0};
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] dw;
        rst_in    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        idle();
        tick();
        tick();
        rst_in = 1'b0;
        tick();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset cpu_rdy", 32'(cpu_rdy), 32'd1);

        // 1: RAM write/read, top address, unmapped read, write-then-read
        bus(32'h0000_0010, 1'b1, 8'hA5);
        bus(32'h0001_FFFF, 1'b1, 8'h3C);
        cpu_wr = 1'b0;
        cpu_a  = 32'h0000_0010; tick();
        chk("t1 read 0x00010", 32'(cpu_rdata), 32'h0000_00A5);
        cpu_a  = 32'h0001_FFFF; tick();
        chk("t1 read 0x1FFFF", 32'(cpu_rdata), 32'h0000_003C);
        cpu_a  = 32'h0002_0000; tick();
        chk("t1 read unmapped", 32'(cpu_rdata), 32'h0000_0000);
        idle();
        bus(32'h0000_0020, 1'b1, 8'h77);
        bus(32'h0000_0020, 1'b0, 8'h00);
        chk("t1 write then read", 32'(cpu_rdata), 32'h0000_0077);

        // 2: zero bytes are dropped on the output path
        out_ready = 1'b1;
        popped.delete();
        bus(32'h0003_0000, 1'b1, 8'h48);
        bus(32'h0003_0000, 1'b1, 8'h00);
        bus(32'h0003_0000, 1'b1, 8'h69);
        repeat (4) tick();
        chk("t2 out count", 32'(popped.size()), 32'd2);
        chk("t2 out[0]", 32'(popped[0]), 32'h0000_0048);
        chk("t2 out[1]", 32'(popped[1]), 32'h0000_0069);

        // 3: output FIFO full back-pressure, held write accepted after one pop
        out_ready = 1'b0;
        popped.delete();
        for (int i = 1; i <= 16; i++) bus(32'h0003_0000, 1'b1, 8'(i));
        chk("t3 rdy low after 16", 32'(cpu_rdy), 32'd0);
        cpu_a = 32'h0003_0000; cpu_wr = 1'b1; cpu_wdata = 8'h11;
        tick();
        chk("t3 write held", 32'(cpu_rdy), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3 rdy after pop", 32'(cpu_rdy), 32'd1);
        tick();
        chk("t3 full again", 32'(cpu_rdy), 32'd0);
        idle();
        out_ready = 1'b1;
        repeat (20) tick();
        chk("t3 out count", 32'(popped.size()), 32'd17);
        for (int i = 0; i < 17; i++) chk("t3 out order", 32'(popped[i]), 32'(i + 1));

        // 4: input FIFO, including push into empty FIFO during a read
        in_valid = 1'b1; in_data = 8'h31; tick();
        in_data  = 8'h32; tick();
        in_valid = 1'b0;
        bus(32'h0003_0000, 1'b0, 8'h00);
        chk("t4 in[0]", 32'(cpu_rdata), 32'h0000_0031);
        bus(32'h0003_0000, 1'b0, 8'h00);
        chk("t4 in[1]", 32'(cpu_rdata), 32'h0000_0032);
        bus(32'h0003_0000, 1'b0, 8'h00);
        chk("t4 in empty", 32'(cpu_rdata), 32'h0000_0000);
        cpu_a = 32'h0003_0000; cpu_wr = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        chk("t4 no bypass", 32'(cpu_rdata), 32'h0000_0000);
        tick();
        chk("t4 byte next read", 32'(cpu_rdata), 32'h0000_0055);
        idle();

        // 5: counter snapshot 100 cycles after reset, then wrap
        rst_in = 1'b1; tick();
        rst_in = 1'b0;
        repeat (100) tick();
        read_dword(dw);
        chk("t5 snapshot dword", dw, 32'd100);
        force dut.cnt_q = 32'hFFFF_FFFF;
        m_cnt_ok = 1'b0;
        tick();
        release dut.cnt_q;
        tick();
        read_dword(dw);
        n_tests++;
        if (dw > 32'd2) begin
            n_fail++;
            $display("FAIL t5 wrap: got 0x%0h, expected at most 0x2", dw);
        end

        // 6: halt, trailing NUL on the output, asynchronous reset mid-burst
        out_ready = 1'b0;
        bus(32'h0003_0000, 1'b1, 8'h41);
        bus(32'h0003_0000, 1'b1, 8'h42);
        in_valid = 1'b1; in_data = 8'h77; tick();
        bus(32'h0000_0010, 1'b0, 8'h00);
        chk("t6 ram kept over reset", 32'(cpu_rdata), 32'h0000_00A5);
        bus(32'h0003_0004, 1'b1, 8'h99);
        chk("t6 halt", 32'(halt), 32'd1);
        chk("t6 rdy low", 32'(cpu_rdy), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("t6 nul valid", 32'(out_valid), 32'd1);
        chk("t6 nul data", 32'(out_data), 32'h0000_0000);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6 rst cpu_rdy", 32'(cpu_rdy), 32'd0);
        chk("t6 rst halt", 32'(halt), 32'd0);
        chk("t6 rst out_valid", 32'(out_valid), 32'd0);
        chk("t6 rst cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("t6 rst in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        rst_in   = 1'b0;
        tick();
        chk("t6 post-rst cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("t6 post-rst in_ready", 32'(in_ready), 32'd1);
        chk("t6 post-rst out_valid", 32'(out_valid), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
